// File: rtl/bac_pkg.sv
// Shared definitions for the Bulls and Cows game sequencer.
//   - state_t      : sequencer states
//   - CODE_*       : seven-segment display codes (0-9 are plain digits)
//   - DISP_*       : full four-digit display words used by the sequencer
//   - valid_entry  : secret/guess legality check (BCD digits, all distinct)
//   - clamp_count  : clamps a bulls/cows count to the displayable range 0..4
package bac_pkg;

  typedef enum logic [2:0] {
    SEC1,
    SEC2,
    GUESS,
    WAIT,
    WIN,
    DRAW
  } state_t;

  localparam logic [3:0] CODE_B     = 4'd11;
  localparam logic [3:0] CODE_C     = 4'd12;
  localparam logic [3:0] CODE_D     = 4'd13;
  localparam logic [3:0] CODE_E     = 4'd14;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  localparam logic [15:0] DISP_SEC1 = {CODE_BLANK, CODE_BLANK, CODE_BLANK, 4'd1};
  localparam logic [15:0] DISP_SEC2 = {CODE_BLANK, CODE_BLANK, CODE_BLANK, 4'd2};
  localparam logic [15:0] DISP_ERR  = {CODE_BLANK, CODE_BLANK, CODE_BLANK, CODE_E};
  localparam logic [15:0] DISP_DRAW = {CODE_D, CODE_D, CODE_D, CODE_D};

  // Legal entry: every nibble is a decimal digit and no digit repeats.
  function automatic logic valid_entry(input logic [15:0] value);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (value[i*4 +: 4] > 4'd9) ok = 1'b0;
      for (int j = i + 1; j < 4; j++) begin
        if (value[i*4 +: 4] == value[j*4 +: 4]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  function automatic logic [2:0] clamp_count(input logic [2:0] count);
    return (count > 3'd4) ? 3'd4 : count;
  endfunction

endpackage

// File: rtl/bac_game_ctrl_btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability counter and
// rising-edge detector.
//   clk, reset : system clock, asynchronous active-low reset
//   btn        : raw asynchronous button level
//   press      : one-cycle pulse per accepted press
// A level change on the synchronized input is accepted only after it has
// held for DEBOUNCE_CYCLES consecutive cycles; any bounce back to the
// accepted level restarts the count.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_q;
  logic [CW-1:0] cnt;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge value of its neighbours, which is what makes the chain a chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      stable_q <= stable;
      press    <= stable & ~stable_q;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bac_game_ctrl.sv
// Bulls and Cows game sequencer.
//   clk, reset     : system clock, asynchronous active-low reset
//   buton          : raw push-button
//   switchgirdi    : four BCD digits from the switch bank, [15:12] leftmost
//   score_start    : one-cycle evaluation request to the scoring datapath
//   score_secret   : opponent's secret, stable while an evaluation is pending
//   score_guess    : captured guess, stable while an evaluation is pending
//   score_done     : one-cycle completion pulse from the scoring datapath
//   score_bulls/cows : evaluation result, valid with score_done
//   disp_digits    : four display codes, [15:12] leftmost
//   tur            : player to act (0 = player 1, 1 = player 2)
//   game_over      : sticky win/draw flag
// Every output is a register; the next-state process computes the whole
// next register set so each output changes one cycle after its cause.
module bac_game_ctrl
  import bac_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_TURNS       = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        buton,
  input  logic [15:0] switchgirdi,
  output logic        score_start,
  output logic [15:0] score_secret,
  output logic [15:0] score_guess,
  input  logic        score_done,
  input  logic [2:0]  score_bulls,
  input  logic [2:0]  score_cows,
  output logic [15:0] disp_digits,
  output logic        tur,
  output logic        game_over
);

  localparam logic [3:0] LAST_TURN = 4'(MAX_TURNS);

  logic        press;
  logic        entry_ok;
  logic [3:0]  turn_next;

  state_t      state, state_d;
  logic [15:0] secret1, secret1_d;
  logic [15:0] secret2, secret2_d;
  logic [3:0]  turn_cnt, turn_cnt_d;
  logic [15:0] disp_d;
  logic        tur_d;
  logic        game_over_d;
  logic        score_start_d;
  logic [15:0] score_secret_d;
  logic [15:0] score_guess_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk   (clk),
    .reset (reset),
    .btn   (buton),
    .press (press)
  );

  assign entry_ok  = valid_entry(switchgirdi);
  assign turn_next = turn_cnt + 4'd1;

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state;
    secret1_d      = secret1;
    secret2_d      = secret2;
    turn_cnt_d     = turn_cnt;
    disp_d         = disp_digits;
    tur_d          = tur;
    score_start_d  = 1'b0;
    score_secret_d = score_secret;
    score_guess_d  = score_guess;

    case (state)
      SEC1: begin
        if (press) begin
          if (entry_ok) begin
            secret1_d = switchgirdi;
            state_d   = SEC2;
            disp_d    = DISP_SEC2;
          end else begin
            disp_d = DISP_ERR;
          end
        end
      end

      SEC2: begin
        if (press) begin
          if (entry_ok) begin
            secret2_d = switchgirdi;
            state_d   = GUESS;
            disp_d    = DISP_SEC2;
          end else begin
            disp_d = DISP_ERR;
          end
        end
      end

      GUESS: begin
        if (press) begin
          if (entry_ok) begin
            // Player 1 attacks player 2's secret and vice versa.
            score_guess_d  = switchgirdi;
            score_secret_d = tur ? secret1 : secret2;
            score_start_d  = 1'b1;
            state_d        = WAIT;
          end else begin
            disp_d = DISP_ERR;
          end
        end
      end

      WAIT: begin
        // Presses are ignored here, including one coincident with score_done.
        if (score_done) begin
          if (score_bulls == 3'd4) begin
            state_d = WIN;
            disp_d  = {12'h000, tur ? 4'd2 : 4'd1};
          end else begin
            disp_d     = {CODE_B, 1'b0, clamp_count(score_bulls),
                          CODE_C, 1'b0, clamp_count(score_cows)};
            turn_cnt_d = turn_next;
            tur_d      = ~tur;
            if (turn_next == LAST_TURN) begin
              state_d = DRAW;
              disp_d  = DISP_DRAW;
            end else begin
              state_d = GUESS;
            end
          end
        end
      end

      WIN, DRAW: ;

      default: begin
        state_d = SEC1;
        disp_d  = DISP_SEC1;
      end
    endcase

    game_over_d = (state_d == WIN) || (state_d == DRAW);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= SEC1;
      secret1      <= '0;
      secret2      <= '0;
      turn_cnt     <= '0;
      disp_digits  <= DISP_SEC1;
      tur          <= 1'b0;
      game_over    <= 1'b0;
      score_start  <= 1'b0;
      score_secret <= '0;
      score_guess  <= '0;
    end else begin
      state        <= state_d;
      secret1      <= secret1_d;
      secret2      <= secret2_d;
      turn_cnt     <= turn_cnt_d;
      disp_digits  <= disp_d;
      tur          <= tur_d;
      game_over    <= game_over_d;
      score_start  <= score_start_d;
      score_secret <= score_secret_d;
      score_guess  <= score_guess_d;
    end
  end

endmodule

// File: doc/bac_game_ctrl.md
# bac_game_ctrl

Game sequencer for the two-player Bulls and Cows design. It takes the raw push-button and the 16-bit switch bank, and steps the game through secret entry, alternating guesses and win detection. It requests each bulls/cows evaluation from the scoring datapath over a start/done handshake. It also produces the four 4-bit display codes consumed by the seven-segment scanner.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000: number of stable `clk` cycles required before a button level change is accepted.
- `MAX_TURNS`, 15: total guesses (both players combined) before the game is declared a draw; range 1..15.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `buton` in 1: raw, asynchronous push-button.
- `switchgirdi` in 16: four BCD digits, [15:12] most significant.
- `score_start` out 1: one-cycle request to the scoring datapath.
- `score_secret` out 16: the opponent's secret, held stable from `score_start` until `score_done`.
- `score_guess` out 16: the captured guess, held stable from `score_start` until `score_done`.
- `score_done` in 1: one-cycle completion pulse from the scoring datapath.
- `score_bulls` in 3: bulls count, valid only while `score_done`=1.
- `score_cows` in 3: cows count, valid only while `score_done`=1.
- `disp_digits` out 16: four display codes, [15:12] drives the leftmost digit.
- `tur` out 1: player to act; 0 = player 1, 1 = player 2.
- `game_over` out 1: sticky flag for a win or a draw.

## Operation
Button path:
- 2-flop synchronizer feeds the debouncer, which feeds a rising-edge detector.
- Output is `press`, a one-cycle pulse.
- One physical press produces exactly one `press`.

Entry validation (applies to secrets and guesses):
- A value is valid when every nibble is ≤9 and all four nibbles are distinct.
- On an invalid value, the FSM stays in its state and `disp_digits` becomes 0xFFFE ("E" in the rightmost digit).

Display codes:
- 0–9: digit.
- 11: "b".
- 12: "C".
- 14: "E".
- 15: blank.

State machine:
- `SEC1`: on a valid `press`, capture the switches into secret1, then go to `SEC2`. Display 0xFFF1.
- `SEC2`: on a valid `press`, capture secret2, then go to `GUESS`. Display 0xFFF2.
- `GUESS`: on a valid `press`, capture the guess, pulse `score_start`, then go to `WAIT`.
  - `score_secret` = secret2 when `tur`=0, secret1 when `tur`=1.
- `WAIT`: all presses are ignored. On `score_done`:
  - Bulls = 4: go to `WIN`; display 0x000P, where P = `tur`+1.
  - Otherwise, display {4'hB, 1'b0, bulls, 4'hC, 1'b0, cows}, increment the turn counter and toggle `tur`.
    - If the counter reaches `MAX_TURNS`: go to `DRAW`, display 0xDDDD.
    - Else: return to `GUESS`.
- `WIN` / `DRAW`: terminal states. `game_over`=1, presses are ignored, only `reset` leaves.

Count handling:
- Bulls and cows are 3 bits wide; values above 4 are clamped to 4 for display.
- The turn counter is 4 bits wide.

## Timing
Reset values:
- State = `SEC1`, `disp_digits` = 0xFFF1.
- `tur`=0, `game_over`=0, `score_start`=0.
- `score_secret`=0, `score_guess`=0.
- Secrets cleared, turn counter = 0, debouncer idle.

Latencies:
- Press-path latency from a `buton` edge is 2 + `DEBOUNCE_CYCLES` + 1 cycles.
- The FSM acts in the same cycle as `press`.
- All outputs are registered; `disp_digits` and the `tur` toggle update on the cycle after `press` or `score_done`.
- `score_start` asserts the cycle after the accepted guess `press` and stays high for exactly 1 cycle.

Handshake:
- `score_done` may arrive no earlier than 1 cycle after `score_start`; there is no upper bound.
- `score_done` outside `WAIT` is ignored.

Simultaneous and reset events:
- `press` in the same cycle as `score_done`: the press is dropped.
- `reset` asserted mid-`WAIT`: the FSM returns to `SEC1`. A `score_done` that arrives after release is ignored.

## Structure
Package `bac_pkg` holds:
- The state enum (`SEC1`, `SEC2`, `GUESS`, `WAIT`, `WIN`, `DRAW`).
- Display code constants (`CODE_B`=11, `CODE_C`=12, `CODE_D`=13, `CODE_E`=14, `CODE_BLANK`=15).
- A `valid_entry` function.

Sub-module:
- `btn_debounce`: synchronizer, counter and edge detector, parameterized by `DEBOUNCE_CYCLES`.
- Simulate with `DEBOUNCE_CYCLES`=4.

## Test plan
- Reset, then press with 0x1234 and 0x5678 → `disp_digits` 0xFFF1 → 0xFFF2 → 0xFFF2 with state `GUESS`, `tur`=0.
- Secret entry 0x1123 → 0xFFFE, state stays `SEC1`. Then 0x1234 → 0xFFF2.
- P1 guesses 0x5687, model returns bulls 2 and cows 2 after 3 cycles:
  - `score_secret`=0x5678 and `score_guess`=0x5687 held throughout.
  - Display 0xB2C2, `tur`=1.
- P2 guesses 0x1234 and the model returns bulls 4 → display 0x0002, `game_over`=1. A further press changes nothing.
- `MAX_TURNS`=2 with two non-winning guesses → display 0xDDDD, `game_over`=1.
- Assert `reset` while in `WAIT`, then deliver `score_done` after release → state `SEC1`, display 0xFFF1, the done pulse is ignored.
- Bouncy button (3 glitches shorter than `DEBOUNCE_CYCLES`, then a stable press) → exactly one capture.
